// File: rtl/io_peripheral_ctrl_pkg.sv
// Shared address map and widths for the LED/switch IO responder.
package io_peripheral_ctrl_pkg;
    localparam logic [31:0] LED_BASE = 32'hFFFF_FC60;
    localparam logic [31:0] SW_BASE  = 32'hFFFF_FC70;
    localparam logic [31:0] LO_OFF   = 32'd0;
    localparam logic [31:0] HI_OFF   = 32'd2;
    localparam int          IO_DW    = 16;
    localparam int          PIN_W    = 24;
endpackage

// File: rtl/io_peripheral_ctrl_if.sv
// CPU-side memory-mapped IO bus between the core data path and the IO responder.
interface io_peripheral_ctrl_if;
    import io_peripheral_ctrl_pkg::*;

    // The chip selects act as valid; the responder is always ready: a write
    // commits on the clock edge it is seen, a read answers in the same cycle.
    logic              led_ctrl;
    logic              switch_ctrl;
    logic [31:0]       addr;
    logic [31:0]       write_data;
    logic [IO_DW-1:0]  io_rdata;

    modport master (
        output led_ctrl, switch_ctrl, addr, write_data,
        input  io_rdata
    );

    modport slave (
        input  led_ctrl, switch_ctrl, addr, write_data,
        output io_rdata
    );
endinterface

// File: rtl/io_peripheral_ctrl_switch_debouncer.sv
// Two-flop synchroniser plus shared-counter debouncer for the board switches.
module io_peripheral_ctrl_switch_debouncer #(
    parameter int W               = 24,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw_raw,
    output logic [W-1:0] sw_db
);
    logic [W-1:0]     sync1;
    logic [W-1:0]     sw_sync;
    logic [W-1:0]     sw_cand;
    logic [CNT_W-1:0] cnt;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sw_sync <= '0;
            sw_cand <= '0;
            cnt     <= '0;
            sw_db   <= '0;
        end else begin
            sync1   <= sw_raw;
            sw_sync <= sync1;
            // Any difference restarts the window; a full window saturates the
            // counter so a long-stable input never wraps back to zero.
            if (sw_sync != sw_cand) begin
                sw_cand <= sw_sync;
                cnt     <= '0;
            end else if (cnt == CNT_LAST) begin
                sw_db <= sw_cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/io_peripheral_ctrl.sv
// IO responder: LED output registers, debounced switch read-back, sticky decode error.
module io_peripheral_ctrl
    import io_peripheral_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                rst,
    io_peripheral_ctrl_if.slave bus,
    input  logic [PIN_W-1:0]    switch_in,
    output logic [PIN_W-1:0]    led_out,
    output logic                addr_err
);
    logic [PIN_W-1:0] sw_db;
    logic led_lo_hit, led_hi_hit, sw_lo_hit, sw_hi_hit;
    logic led_bad, sw_bad;
    logic unused_wdata;

    assign unused_wdata = ^{bus.write_data[31:16]};

    assign led_lo_hit = bus.led_ctrl    && (bus.addr == LED_BASE + LO_OFF);
    assign led_hi_hit = bus.led_ctrl    && (bus.addr == LED_BASE + HI_OFF);
    assign sw_lo_hit  = bus.switch_ctrl && (bus.addr == SW_BASE + LO_OFF);
    assign sw_hi_hit  = bus.switch_ctrl && (bus.addr == SW_BASE + HI_OFF);
    assign led_bad    = bus.led_ctrl    && !(led_lo_hit || led_hi_hit);
    assign sw_bad     = bus.switch_ctrl && !(sw_lo_hit  || sw_hi_hit);

    io_peripheral_ctrl_switch_debouncer #(
        .W               (PIN_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debouncer (
        .clk    (clk),
        .rst    (rst),
        .sw_raw (switch_in),
        .sw_db  (sw_db)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out  <= '0;
            addr_err <= 1'b0;
        end else begin
            if (led_lo_hit) led_out[15:0]  <= bus.write_data[15:0];
            if (led_hi_hit) led_out[23:16] <= bus.write_data[7:0];
            if (led_bad || sw_bad) addr_err <= 1'b1;
        end
    end

    // Read path is combinational so the CPU sees data in the select cycle.
    always_comb begin
        bus.io_rdata = '0;
        if (sw_lo_hit)      bus.io_rdata = sw_db[15:0];
        else if (sw_hi_hit) bus.io_rdata = {8'h00, sw_db[23:16]};
    end
endmodule
